// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
  } dmem_req_t;

  typedef enum logic {RSP_OK, RSP_ERR} rsp_e;

  // End address is formed in 65 bits so an access near 2^64 cannot wrap into range.
  function automatic logic is_legal_access(input logic [63:0] addr, input logic [3:0] size,
                                           input logic [64:0] mem_size);
    logic        size_ok;
    logic        align_ok;
    logic [64:0] end_addr;
    size_ok  = (size == 4'd1) || (size == 4'd2) || (size == 4'd4) || (size == 4'd8);
    align_ok = (addr & {60'd0, size - 4'd1}) == 64'd0;
    end_addr = {1'b0, addr} + {61'd0, size};
    return size_ok && align_ok && (end_addr <= mem_size);
  endfunction

  function automatic logic [63:0] size_mask(input logic [3:0] size);
    case (size)
      4'd1:    return 64'h0000_0000_0000_00ff;
      4'd2:    return 64'h0000_0000_0000_ffff;
      4'd4:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin picker with one-hot grant; optional lock hold under DMEM_ARB_LOCK_EN.
module dmem_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic [1:0] grant
);

  logic last_grant;
`ifdef DMEM_ARB_LOCK_EN
  logic lock_act;
  logic lock_port;
`endif

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
`ifdef DMEM_ARB_LOCK_EN
    if (lock_act && valid[lock_port]) grant = lock_port ? 2'b10 : 2'b01;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
`ifdef DMEM_ARB_LOCK_EN
      lock_act   <= 1'b0;
      lock_port  <= 1'b0;
`endif
    end else begin
      if (|grant) last_grant <= grant[1];
`ifdef DMEM_ARB_LOCK_EN
      // A cycle with no acceptance means the locked port dropped valid: release.
      lock_act  <= (|grant) && lock[grant[1]];
      lock_port <= grant[1];
`endif
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the data memory: grant, issue stage, response capture.
// Optional DMEM_ARB_LOCK_EN adds reqN_lock inputs that hold the grant on the locked port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [3:0]        req0_size,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [3:0]        req1_size,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [3:0]        mem_xfer_size,
  input  logic [DATA_W-1:0] mem_read_data
);

  dmem_req_t [1:0] req;
  dmem_req_t       sel;
  logic [1:0]      grant;
  logic            gsel;
  logic            accept;
  logic            legal;

  assign req[0] = '{write: req0_write, addr: req0_addr, wdata: req0_wdata, size: req0_size};
  assign req[1] = '{write: req1_write, addr: req1_addr, wdata: req1_wdata, size: req1_size};

  dmem_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
`ifdef DMEM_ARB_LOCK_EN
    .lock  ({req1_lock, req0_lock}),
`endif
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign gsel       = grant[1];
  assign sel        = req[gsel];
  assign legal      = is_legal_access(sel.addr, sel.size, 65'(MEM_SIZE));

  // Issue stage: mem_* are registered; address/data hold while idle or on illegal accesses.
  logic       iss_vld;
  logic       iss_port;
  rsp_e       iss_rsp;
  logic [3:0] iss_size;

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_vld          <= 1'b0;
      iss_port         <= 1'b0;
      iss_rsp          <= RSP_OK;
      iss_size         <= 4'd8;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_xfer_size    <= 4'd8;
    end else begin
      iss_vld          <= accept;
      mem_write_enable <= accept && legal && sel.write;
      mem_read_enable  <= accept && legal && !sel.write;
      if (accept) begin
        iss_port <= gsel;
        iss_rsp  <= legal ? RSP_OK : RSP_ERR;
        iss_size <= sel.size;
        if (legal) begin
          mem_address    <= sel.addr;
          mem_write_data <= sel.wdata;
          mem_xfer_size  <= sel.size;
        end
      end
    end
  end

  // Response stage: read data is only present when the issue stage actually read.
  logic [1:0]             rvalid;
  logic [1:0]             err;
  logic [1:0][DATA_W-1:0] rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rvalid <= '0;
      err    <= '0;
      rdata  <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        rvalid[p] <= iss_vld && (iss_port == 1'(p));
        err[p]    <= iss_vld && (iss_port == 1'(p)) && (iss_rsp == RSP_ERR);
        if (iss_vld && (iss_port == 1'(p)))
          rdata[p] <= mem_read_enable ? (mem_read_data & size_mask(iss_size)) : '0;
      end
    end
  end

  assign req0_rvalid = rvalid[0];
  assign req1_rvalid = rvalid[1];
  assign req0_err    = err[0];
  assign req1_err    = err[1];
  assign req0_rdata  = rdata[0];
  assign req1_rdata  = rdata[1];

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter for the single-ported, little-endian data memory. Typical requesters: CPU load/store unit on port 0, test loader/debug port on port 1.
- Registers one granted request per cycle into an issue stage that drives the memory port.
- Captures the memory's combinational read data into a per-requester response register.
- Screens out illegal accesses (misaligned, non-power-of-2 size, out-of-bounds) before they reach memory and returns an error instead.

Parameters:
- MEM_SIZE, 1024: memory size in bytes; power of two, >8.
- ADDR_W, 64: address width.
- DATA_W, 64: data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- reqN_valid  in  1  request present (N = 0,1).
- reqN_ready  out  1  request accepted this cycle (combinational grant).
- reqN_write  in  1  1 = store, 0 = load.
- reqN_addr  in  64  byte address.
- reqN_wdata  in  64  store data, little-endian, low bytes used.
- reqN_size  in  4  transfer size in bytes: 1, 2, 4 or 8.
- reqN_rvalid  out  1  one-cycle response pulse.
- reqN_rdata  out  64  load data; 0 for stores and errors.
- reqN_err  out  1  qualifies rvalid; illegal access.
- mem_address  out  64  to memory address.
- mem_write_enable  out  1  to memory.
- mem_read_enable  out  1  to memory.
- mem_write_data  out  64  to memory.
- mem_xfer_size  out  4  to memory.
- mem_read_data  in  64  from memory, combinational.

Behaviour:
- Reset (reset==0 at posedge): issue stage empties; mem_write_enable and mem_read_enable go 0; mem_address, mem_write_data, mem_xfer_size go 0, with mem_xfer_size = 8.
- Reset also clears all rvalid, err and rdata to 0 and sets last_grant=1, so port 0 wins first.
- Reset mid-operation drops the in-flight access. A write already presented in the same edge is not guaranteed.
- Grant (combinational):
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - reqN_ready = grantN. No request waits more than 1 cycle while it holds valid.
- Handshake: valid&ready in cycle T = accepted. A requester holding valid without ready must keep its fields stable.
- last_grant updates at every accepted transfer.
- Legality check, evaluated on the granted request in cycle T:
  - size ∈ {1,2,4,8};
  - (addr & (size-1)) == 0;
  - addr + size <= MEM_SIZE, computed in 65 bits so there is no wrap.
- Cycle T+1, legal request: the issue stage drives the mem_* signals, with exactly one of write/read enable = 1.
  - A write commits at the end of T+1.
  - On a read, mem_read_data is sampled at the end of T+1.
- Cycle T+1, illegal request: both enables stay 0 and an error is tagged for the requester.
- Cycle T+2: the owning port sees rvalid=1 for exactly 1 cycle.
  - Load: rdata = memory bytes; only the low 8*size bits are kept, the rest are zeroed.
  - Store: rdata = 0.
  - Error: err=1, rdata = 0.
- Throughput: 1 access/cycle sustained. Back-to-back grants alternate between ports when both are valid.
- Issue-stage enables are 0 in any cycle following no acceptance (idle).
- Write-then-read to the same address in consecutive accepted cycles returns the new data, because the write commits before the read issues.
- No X propagation: while idle, mem_address holds its last value and the enables are 0.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - Adds input reqN_lock (1 bit) per port.
  - If the accepted request had lock=1, the next cycle's grant is forced to the same port whenever that port is valid, overriding round-robin. This supports atomic multi-beat sequences.
  - The lock releases on the first accepted request with lock=0, or on the first cycle the locked port drops valid.
  - last_grant still updates normally.
- Without the macro: no lock ports; pure round-robin.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef struct dmem_req_t {write, addr[63:0], wdata[63:0], size[3:0]};
  - typedef enum {RSP_OK, RSP_ERR};
  - function is_legal_access(addr, size, mem_size);
  - function size_mask(size), returning a 64-bit keep-mask.
- One sub-module: dmem_rr_arb2 (2-way round-robin picker holding last_grant and the optional lock state). Outputs a one-hot grant.

Test Plan:
- Reset with both requesters valid: release reset, port0 write addr 0x10 size 8 data 0x1122334455667788, port1 read addr 0x10 size 8 → cycle 1 grants port0; port1 granted next cycle and gets rvalid with rdata 0x1122334455667788 and err=0.
- Sustained contention: both valid for 8 cycles → grants alternate 0,1,0,1…; each port sees 4 rvalid pulses, 2 cycles after each of its accepts; mem enables high every cycle.
- Illegal accesses:
  - addr 0x3 size 4 → err=1, no mem enable;
  - size 3 → err;
  - addr 0x3FC size 8 → err;
  - addr 0x3F8 size 8 → legal.
- Byte granularity: write size 1 addr 0x21 data 0xAB, then read size 2 addr 0x20 → rdata[15:8]=0xAB, rdata[63:16]=0.
- Reset mid-flight: accept a read, then assert reset the next cycle → no rvalid ever appears for it; enables are 0 after reset.
- With DMEM_ARB_LOCK_EN: port1 issues 3 locked requests while port0 is valid → port1 granted 3 consecutive cycles, then port0.
